// File: rtl/dht11_pkg.sv
// dht11_pkg: shared DHT11 state encoding, default protocol timing and checksum helper
package dht11_pkg;
   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_START_LOW  = 4'd1,
      ST_WAIT_DELAY = 4'd2,
      ST_RESP_LOW   = 4'd3,
      ST_RESP_HIGH  = 4'd4,
      ST_BIT_LOW    = 4'd5,
      ST_BIT_HIGH   = 4'd6,
      ST_END_LOW    = 4'd7
   } dht11_state_e;
   localparam int DEF_CLK_FREQ_MHZ  = 100;
   localparam int DEF_START_MIN_US  = 18000;
   localparam int DEF_RESP_DELAY_US = 30;
   localparam int DEF_RESP_LOW_US   = 80;
   localparam int DEF_RESP_HIGH_US  = 80;
   localparam int DEF_BIT_LOW_US    = 50;
   localparam int DEF_BIT0_HIGH_US  = 28;
   localparam int DEF_BIT1_HIGH_US  = 70;
   localparam int FRAME_BITS        = 40;
   localparam int US_CNT_W          = 20;
   function automatic logic [7:0] dht11_checksum(input logic [7:0] a, input logic [7:0] b,
                                                 input logic [7:0] c, input logic [7:0] d);
      return a + b + c + d;
   endfunction
endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick: restartable prescaler producing one tick every CLK_FREQ_MHZ clocks
//   clk, rst : clock and synchronous active-high reset
//   restart  : clear the prescaler so the next tick lands a full microsecond later
//   tick     : high on the last clock of each microsecond
module dht11_us_tick
   import dht11_pkg::*;
#(
   parameter int CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);
   localparam int W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
   logic [W-1:0] cnt_q, cnt_d;
   assign tick = cnt_q == W'(CLK_FREQ_MHZ - 1);
   always_comb cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/dht11_sensor_model.sv
// dht11_sensor_model: DHT11 sensor-side responder for the single-wire protocol
//   clk, rst                      : clock and synchronous active-high reset
//   rh_int, rh_dec, t_int, t_dec  : data bytes, sampled when a valid start is accepted
//   corrupt_checksum              : invert the transmitted checksum (error injection)
//   dht11_io                      : bidirectional bus, push-pull during sensor phases, else Z
//   busy                          : high from WAIT_DELAY through END_LOW
//   frame_done                    : one-cycle pulse in the first IDLE cycle after a full frame
//   state_dbg                     : current FSM state encoding
module dht11_sensor_model
   import dht11_pkg::*;
#(
   parameter int CLK_FREQ_MHZ  = DEF_CLK_FREQ_MHZ,
   parameter int START_MIN_US  = DEF_START_MIN_US,
   parameter int RESP_DELAY_US = DEF_RESP_DELAY_US,
   parameter int RESP_LOW_US   = DEF_RESP_LOW_US,
   parameter int RESP_HIGH_US  = DEF_RESP_HIGH_US,
   parameter int BIT_LOW_US    = DEF_BIT_LOW_US,
   parameter int BIT0_HIGH_US  = DEF_BIT0_HIGH_US,
   parameter int BIT1_HIGH_US  = DEF_BIT1_HIGH_US
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rh_int,
   input  logic [7:0] rh_dec,
   input  logic [7:0] t_int,
   input  logic [7:0] t_dec,
   input  logic       corrupt_checksum,
   inout  wire        dht11_io,
   output logic       busy,
   output logic       frame_done,
   output logic [3:0] state_dbg
);
   dht11_state_e          state_q, state_d;
   logic [1:0]            sync_q, sync_d;
   logic [US_CNT_W-1:0]   us_q, us_d, us_inc, phase_us;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [5:0]            bit_q, bit_d;
   logic                  frame_done_q, frame_done_d;
   logic                  tick, line, phase_end, drive_en, drive_val, restart;

   assign restart = state_d != state_q;

   dht11_us_tick #(.CLK_FREQ_MHZ(CLK_FREQ_MHZ)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   assign line       = sync_q[1];
   assign drive_en   = state_q inside {ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH, ST_END_LOW};
   assign drive_val  = state_q == ST_RESP_HIGH || state_q == ST_BIT_HIGH;
   assign dht11_io   = drive_en ? drive_val : 1'bz;
   assign busy       = state_q >= ST_WAIT_DELAY;
   assign frame_done = frame_done_q;
   assign state_dbg  = state_q;

   // While we drive the line our own levels are meaningless as host activity, so the
   // synchronizer is parked high; this keeps the END_LOW level from reading as a new start.
   always_comb begin
      sync_d    = drive_en ? 2'b11 : {sync_q[0], dht11_io};
      us_inc    = (tick && us_q != '1) ? us_q + 1'b1 : us_q;
      phase_us  = state_q == ST_WAIT_DELAY ? US_CNT_W'(RESP_DELAY_US) :
                  state_q == ST_RESP_LOW   ? US_CNT_W'(RESP_LOW_US) :
                  state_q == ST_RESP_HIGH  ? US_CNT_W'(RESP_HIGH_US) :
                  state_q == ST_BIT_HIGH   ? (shift_q[FRAME_BITS-1] ? US_CNT_W'(BIT1_HIGH_US)
                                                                    : US_CNT_W'(BIT0_HIGH_US)) :
                                             US_CNT_W'(BIT_LOW_US);
      phase_end = tick && us_inc == phase_us;
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_d        = bit_q;
      frame_done_d = 1'b0;
      case (state_q)
         ST_IDLE:       if (!line) state_d = ST_START_LOW;
         // us_inc includes the tick of the current cycle, so a low of exactly
         // START_MIN_US microseconds is accepted.
         ST_START_LOW:  if (line) begin
            if (us_inc >= US_CNT_W'(START_MIN_US)) begin
               state_d = ST_WAIT_DELAY;
               shift_d = {rh_int, rh_dec, t_int, t_dec,
                          dht11_checksum(rh_int, rh_dec, t_int, t_dec) ^ {8{corrupt_checksum}}};
               bit_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_DELAY: if (phase_end) state_d = ST_RESP_LOW;
         ST_RESP_LOW:   if (phase_end) state_d = ST_RESP_HIGH;
         ST_RESP_HIGH:  if (phase_end) state_d = ST_BIT_LOW;
         ST_BIT_LOW:    if (phase_end) state_d = ST_BIT_HIGH;
         ST_BIT_HIGH:   if (phase_end) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            bit_d   = bit_q + 1'b1;
            state_d = bit_q == 6'(FRAME_BITS - 1) ? ST_END_LOW : ST_BIT_LOW;
         end
         ST_END_LOW:    if (phase_end) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
         end
         default:       state_d = ST_IDLE;
      endcase
      us_d = (state_d != state_q || state_q == ST_IDLE) ? '0 : us_inc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sync_q       <= 2'b11;
         us_q         <= '0;
         shift_q      <= '0;
         bit_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         us_q         <= us_d;
         shift_q      <= shift_d;
         bit_q        <= bit_d;
         frame_done_q <= frame_done_d;
      end
   end
endmodule

// File: tb/tb_dht11_sensor_model.sv
// tb_dht11_sensor_model: scoreboard bench decoding the DHT11 responder waveform
module tb_dht11_sensor_model;
   localparam int CLK_MHZ  = 2;
   localparam int START_US = 200;

   typedef struct {
      logic        abort;
      logic [39:0] bits;
      int          len;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rh_int = 8'h00, rh_dec = 8'h00, t_int = 8'h00, t_dec = 8'h00;
   logic       corrupt = 1'b0;
   logic       host_low = 1'b0;
   wire        dht11_io;
   logic       busy, frame_done;
   logic [3:0] state_dbg;

   int          tests = 0, fails = 0, fd_seen = 0;
   exp_t        exp_q[$];
   exp_t        e;
   logic        in_frame = 1'b0;
   logic        prev_line;
   int          seg, run, total;
   logic [39:0] got;

   pullup (dht11_io);
   assign dht11_io = host_low ? 1'b0 : 1'bz;

   dht11_sensor_model #(.CLK_FREQ_MHZ(CLK_MHZ), .START_MIN_US(START_US)) dut (
      .clk              (clk),
      .rst              (rst),
      .rh_int           (rh_int),
      .rh_dec           (rh_dec),
      .t_int            (t_int),
      .t_dec            (t_dec),
      .corrupt_checksum (corrupt),
      .dht11_io         (dht11_io),
      .busy             (busy),
      .frame_done       (frame_done),
      .state_dbg        (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int frame_len(input logic [39:0] b);
      int n = 30 + 80 + 80 + 40 * 50 + 50;
      for (int i = 0; i < 40; i++) n += b[i] ? 70 : 28;
      return n * CLK_MHZ;
   endfunction

   // Segment order: delay high, response low, response high, 40 x (low, high), end low.
   task automatic close_seg();
      int exp_len;
      exp_len = seg == 0 ? 30 : seg <= 2 ? 80 : seg % 2 == 1 ? 50 : run == 70 * CLK_MHZ ? 70 : 28;
      if (seg > 83) begin
         tests++;
         fails++;
         $display("FAIL extra_segment: got segment %0d, expected at most 83", seg);
      end
      if (seg >= 4 && seg % 2 == 0) got = {got[38:0], run == 70 * CLK_MHZ};
      check($sformatf("seg%0d_len", seg), run, exp_len * CLK_MHZ);
      check($sformatf("seg%0d_level", seg), prev_line, seg % 2 == 0);
   endtask

   always @(negedge clk) begin
      if (frame_done) fd_seen++;
      if (!in_frame) begin
         if (busy) begin
            in_frame  = 1'b1;
            seg       = 0;
            run       = 1;
            total     = 1;
            got       = '0;
            prev_line = dht11_io;
         end
      end else if (busy) begin
         total++;
         if (dht11_io === prev_line) run++;
         else begin
            close_seg();
            seg++;
            run       = 1;
            prev_line = dht11_io;
         end
      end else begin
         in_frame = 1'b0;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got a frame of %0d cycles, expected none", total);
         end else begin
            e = exp_q.pop_front();
            if (e.abort) begin
               check("abort_no_frame_done", frame_done, 1'b0);
               check("abort_state_idle", state_dbg, 4'd0);
            end else begin
               close_seg();
               check("seg_count", seg, 83);
               check("frame_bits", got, e.bits);
               check("frame_len", total, e.len);
               check("frame_done_at_idle", frame_done, 1'b1);
               check("state_idle_after_frame", state_dbg, 4'd0);
            end
         end
      end
   end

   task automatic host_start(input int cycles);
      @(posedge clk);
      #1 host_low = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 host_low = 1'b0;
   endtask

   task automatic wait_busy(input logic lvl, input int limit);
      int n = 0;
      while (busy !== lvl && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (busy !== lvl) begin
         tests++;
         fails++;
         $display("FAIL wait_busy: got busy=%0b after %0d cycles, expected %0b", busy, n, lvl);
      end
   endtask

   task automatic wait_entries(input logic [3:0] s, input int n);
      int   seen = 0, cyc = 0;
      logic prev = 1'b0;
      while (seen < n && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (state_dbg == s && !prev) seen++;
         prev = state_dbg == s;
      end
      if (seen < n) begin
         tests++;
         fails++;
         $display("FAIL wait_state%0d: got %0d entries, expected %0d", s, seen, n);
      end
   endtask

   task automatic push_exp(input logic abort, input logic [39:0] bits);
      exp_t x;
      x.abort = abort;
      x.bits  = bits;
      x.len   = frame_len(bits);
      exp_q.push_back(x);
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic corr, input logic [7:0] cs);
      rh_int  = a;
      rh_dec  = b;
      t_int   = c;
      t_dec   = d;
      corrupt = corr;
      push_exp(1'b0, {a, b, c, d, cs});
      host_start(START_US * CLK_MHZ);
      wait_busy(1'b1, 20);
      wait_busy(1'b0, 12000);
      repeat (20) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", state_dbg, 4'd0);
      check("reset_busy", busy, 1'b0);
      check("reset_frame_done", frame_done, 1'b0);
      check("reset_line", dht11_io, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);

      send(8'hAA, 8'h0F, 8'hC6, 8'h00, 1'b0, 8'h7F);

      @(posedge clk);
      #1 host_low = 1'b1;
      repeat (20) @(posedge clk);
      #1 check("start_low_state", state_dbg, 4'd1);
      repeat (80) @(posedge clk);
      #1 host_low = 1'b0;
      repeat (10) @(negedge clk);
      check("short_start_busy", busy, 1'b0);
      check("short_start_state", state_dbg, 4'd0);
      check("short_start_line", dht11_io, 1'b1);
      host_start(START_US * CLK_MHZ - 1);
      repeat (10) @(negedge clk);
      check("boundary_start_busy", busy, 1'b0);
      check("boundary_start_state", state_dbg, 4'd0);

      send(8'hAA, 8'h0F, 8'hC6, 8'h00, 1'b1, 8'h80);

      rh_int  = 8'hAA;
      corrupt = 1'b0;
      push_exp(1'b0, {8'hAA, 8'h0F, 8'hC6, 8'h00, 8'h7F});
      host_start(START_US * CLK_MHZ);
      wait_busy(1'b1, 20);
      wait_entries(4'd5, 4);
      rh_int = 8'h55;
      wait_busy(1'b0, 12000);
      repeat (20) @(negedge clk);
      send(8'h55, 8'h0F, 8'hC6, 8'h00, 1'b0, 8'h2A);

      rh_int = 8'h12;
      rh_dec = 8'h34;
      t_int  = 8'h56;
      t_dec  = 8'h78;
      push_exp(1'b1, '0);
      host_start(START_US * CLK_MHZ);
      wait_busy(1'b1, 20);
      wait_entries(4'd6, 21);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_state", state_dbg, 4'd0);
      check("rst_line", dht11_io, 1'b1);
      check("rst_frame_done", frame_done, 1'b0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      send(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 8'h14);

      send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hFC);

      repeat (20) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      check("monitor_idle", in_frame, 1'b0);
      check("frame_done_count", fd_seen, 6);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
